sgdh_traffic_light_monitor: RTL and testbench

SGDH_TRAFFIC_LIGHT_MONITOR -- requirements
Module: sgdh_traffic_light_monitor

---
 rtl/sgdh_traffic_light_monitor_pkg.sv | 21 ++
 rtl/sgdh_traffic_light_chk.sv | 62 ++++++
 rtl/sgdh_traffic_light_monitor.sv | 46 ++++
 tb/tb_sgdh_traffic_light_monitor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/sgdh_traffic_light_monitor_pkg.sv
// sgdh_traffic_light_monitor_pkg: light encodings, checker states, error-bit indices and helpers.
package sgdh_traffic_light_monitor_pkg;
  localparam logic [2:0] L_DARK   = 3'b000;
  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_RED    = 3'b100;
  localparam int E_DWELL = 0;
  localparam int E_SEQ   = 1;
  localparam int E_CODE  = 2;
  typedef enum logic [2:0] {ST_INIT, ST_RED, ST_GREEN, ST_YELLOW, ST_DARK} state_t;
  function automatic state_t to_state(logic [2:0] l);
    return l == L_RED ? ST_RED : l == L_GREEN ? ST_GREEN : l == L_YELLOW ? ST_YELLOW : ST_DARK;
  endfunction
  function automatic logic step_ok(state_t s, state_t n);
    return n == ST_DARK || (s == ST_RED && n == ST_GREEN) || (s == ST_GREEN && n == ST_YELLOW) ||
           (s == ST_YELLOW && n == ST_RED) || (s == ST_DARK && n == ST_RED);
  endfunction
  function automatic logic is_go(logic [2:0] l);
    return l == L_GREEN || l == L_YELLOW;
  endfunction
endpackage

// File: rtl/sgdh_traffic_light_chk.sv
// sgdh_traffic_light_chk: single-channel sequence, code and dwell checker with cycle counter.
module sgdh_traffic_light_chk
  import sgdh_traffic_light_monitor_pkg::*;
#(
  parameter int unsigned RED_TIME    = 3*125000000,
  parameter int unsigned YELLOW_TIME = 1*125000000,
  parameter int unsigned GREEN_TIME  = 2*125000000,
  parameter int unsigned TOL         = 2
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        mon_en,
  input  logic        clr_err,
  input  logic [2:0]  light,
  output logic [2:0]  light_q,
  output logic        active,
  output logic [2:0]  err,
  output logic [15:0] cycles
);
  state_t state, state_nxt, obs;
  logic [31:0] cnt, t;
  logic [2:0] ev;
  logic exempt, legal, chg, timed, cyc_inc;
  // mon_en is registered with the light so both describe the same sample
  always_ff @(posedge clk or negedge areset)
    if (!areset) begin
      light_q <= L_DARK;
      active  <= 1'b0;
      state   <= ST_INIT;
    end else begin
      light_q <= light;
      active  <= mon_en;
      state   <= state_nxt;
    end
  always_comb begin
    legal     = $onehot0(light_q);
    obs       = to_state(light_q);
    chg       = active && legal && obs != state;
    state_nxt = !active ? ST_INIT : chg ? obs : state;
  end
  always_comb begin
    t              = state == ST_RED ? 32'(RED_TIME) : state == ST_GREEN ? 32'(GREEN_TIME) : 32'(YELLOW_TIME);
    timed          = !exempt && (state == ST_RED || state == ST_GREEN || state == ST_YELLOW);
    ev[E_CODE]     = active && !legal;
    ev[E_SEQ]      = chg && state != ST_INIT && !step_ok(state, obs);
    // overstay fires once as the count steps past the window; exit then only checks the low side
    ev[E_DWELL]    = timed && (chg ? {1'b0, cnt} + 33'(TOL) < {1'b0, t} : active && legal && cnt == t + 32'(TOL));
    cyc_inc        = chg && state == ST_YELLOW && obs == ST_RED;
  end
  always_ff @(posedge clk or negedge areset)
    if (!areset) begin
      cnt    <= '0;
      exempt <= 1'b0;
      err    <= '0;
      cycles <= '0;
    end else begin
      cnt    <= chg ? 32'd1 : (active && legal && !(&cnt)) ? cnt + 32'd1 : cnt;
      exempt <= chg ? state == ST_INIT : exempt;
      err    <= (clr_err ? 3'b000 : err) | ev;
      cycles <= cycles + {15'd0, cyc_inc && !(&cycles)};
    end
endmodule

// File: rtl/sgdh_traffic_light_monitor.sv
// sgdh_traffic_light_monitor: two-channel traffic light checker with cross-channel conflict flag.
module sgdh_traffic_light_monitor
  import sgdh_traffic_light_monitor_pkg::*;
#(
  parameter int unsigned RED_TIME_C0    = 3*125000000,
  parameter int unsigned YELLOW_TIME_C0 = 1*125000000,
  parameter int unsigned GREEN_TIME_C0  = 2*125000000,
  parameter int unsigned RED_TIME_C1    = 3*125000000,
  parameter int unsigned YELLOW_TIME_C1 = 1*125000000,
  parameter int unsigned GREEN_TIME_C1  = 2*125000000,
  parameter int unsigned TOL            = 2,
  parameter int          CONFLICT_CHK   = 1
) (
  input  logic        clk,
  input  logic        areset,
  input  logic        mon_en,
  input  logic        clr_err,
  input  logic [2:0]  light_c0,
  input  logic [2:0]  light_c1,
  output logic [2:0]  err_c0,
  output logic [2:0]  err_c1,
  output logic        err_conflict,
  output logic        err_any,
  output logic [15:0] cycles_c0,
  output logic [15:0] cycles_c1
);
  logic [2:0] lq0, lq1;
  logic act0, act1;
  sgdh_traffic_light_chk #(
    .RED_TIME(RED_TIME_C0), .YELLOW_TIME(YELLOW_TIME_C0), .GREEN_TIME(GREEN_TIME_C0), .TOL(TOL)
  ) u_c0 (
    .clk(clk), .areset(areset), .mon_en(mon_en), .clr_err(clr_err), .light(light_c0),
    .light_q(lq0), .active(act0), .err(err_c0), .cycles(cycles_c0)
  );
  sgdh_traffic_light_chk #(
    .RED_TIME(RED_TIME_C1), .YELLOW_TIME(YELLOW_TIME_C1), .GREEN_TIME(GREEN_TIME_C1), .TOL(TOL)
  ) u_c1 (
    .clk(clk), .areset(areset), .mon_en(mon_en), .clr_err(clr_err), .light(light_c1),
    .light_q(lq1), .active(act1), .err(err_c1), .cycles(cycles_c1)
  );
  always_ff @(posedge clk or negedge areset)
    if (!areset) err_conflict <= 1'b0;
    else err_conflict <= (clr_err ? 1'b0 : err_conflict) |
                         (CONFLICT_CHK != 0 && act0 && act1 && is_go(lq0) && is_go(lq1));
  assign err_any = |err_c0 || |err_c1 || err_conflict;
endmodule

// File: tb/tb_sgdh_traffic_light_monitor.sv
// tb_sgdh_traffic_light_monitor: directed scenarios plus random light streams, scoreboarded
// against an interval-based reference model of the monitor rules.
module tb_sgdh_traffic_light_monitor;
  localparam int RED = 6, YEL = 2, GRN = 4, TOL = 1;
  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, D = 3'b000;
  logic clk = 1'b0, areset = 1'b0, mon_en = 1'b0, clr_err = 1'b0;
  logic [2:0] light_c0 = D, light_c1 = D;
  logic [2:0] err_c0, err_c1;
  logic err_conflict, err_any;
  logic [15:0] cycles_c0, cycles_c1;
  sgdh_traffic_light_monitor #(
    .RED_TIME_C0(RED), .YELLOW_TIME_C0(YEL), .GREEN_TIME_C0(GRN),
    .RED_TIME_C1(RED), .YELLOW_TIME_C1(YEL), .GREEN_TIME_C1(GRN),
    .TOL(TOL), .CONFLICT_CHK(1)
  ) dut (
    .clk(clk), .areset(areset), .mon_en(mon_en), .clr_err(clr_err),
    .light_c0(light_c0), .light_c1(light_c1), .err_c0(err_c0), .err_c1(err_c1),
    .err_conflict(err_conflict), .err_any(err_any), .cycles_c0(cycles_c0), .cycles_c1(cycles_c1)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [2:0] e0, e1;
    logic cf, any;
    logic [15:0] c0, c1;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int errors = 0, checks = 0;
  // reference model: current interval colour (-1 before first sample), its length, and the flags
  int col[2], cyc[2];
  int unsigned len[2];
  bit exm[2];
  logic [2:0] flg[2], lq[2];
  bit enq, cf;
  int gcol[2], grem[2];
  function automatic int tim(int c);
    return c == 4 ? RED : c == 1 ? GRN : c == 2 ? YEL : 0;
  endfunction
  function automatic int ring(int c);
    return c == 4 ? 0 : c == 1 ? 1 : c == 2 ? 2 : -1;
  endfunction
  function automatic bit succ_ok(int a, int b);
    return b == 0 || (a == 0 && b == 4) || (ring(a) >= 0 && ring(b) == (ring(a) + 1) % 3);
  endfunction
  function automatic bit go(logic [2:0] l);
    return l == G || l == Y;
  endfunction
  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      col[c] = -1; cyc[c] = 0; len[c] = 0; exm[c] = 0; flg[c] = '0; lq[c] = D;
    end
    enq = 0; cf = 0;
  endtask
  task automatic model_step(input bit en, input bit clr, input logic [2:0] a, input logic [2:0] b);
    bit ce;
    ce = enq && go(lq[0]) && go(lq[1]);
    cf = (clr ? 1'b0 : cf) | ce;
    for (int c = 0; c < 2; c++) begin
      logic [2:0] ev;
      int l;
      ev = '0;
      l = int'(lq[c]);
      if (!enq) col[c] = -1;
      else if (!(l == 0 || l == 1 || l == 2 || l == 4)) ev[2] = 1'b1;
      else if (col[c] < 0) begin
        col[c] = l; len[c] = 1; exm[c] = 1;
      end else if (l != col[c]) begin
        if (!exm[c] && col[c] != 0 && int'(len[c]) + TOL < tim(col[c])) ev[0] = 1'b1;
        if (!succ_ok(col[c], l)) ev[1] = 1'b1;
        if (col[c] == 2 && l == 4 && cyc[c] < 65535) cyc[c]++;
        col[c] = l; len[c] = 1; exm[c] = 0;
      end else begin
        if (len[c] != 32'hFFFF_FFFF) len[c]++;
        if (!exm[c] && col[c] != 0 && int'(len[c]) == tim(col[c]) + TOL + 1) ev[0] = 1'b1;
      end
      flg[c] = (clr ? 3'b000 : flg[c]) | ev;
    end
    lq[0] = a; lq[1] = b; enq = en;
  endtask
  task automatic cyc_step(input bit rn, input bit en, input bit clr, input logic [2:0] a, input logic [2:0] b);
    exp_t x;
    @(negedge clk);
    areset = rn; mon_en = en; clr_err = clr; light_c0 = a; light_c1 = b;
    if (!rn) model_reset();
    else model_step(en, clr, a, b);
    x.e0 = flg[0]; x.e1 = flg[1]; x.cf = cf;
    x.any = |flg[0] || |flg[1] || cf;
    x.c0 = 16'(cyc[0]); x.c1 = 16'(cyc[1]);
    q.push_back(x);
  endtask
  task automatic run(input logic [2:0] a, input logic [2:0] b, input int n, input bit en = 1, input bit clr = 0);
    repeat (n) cyc_step(1, en, clr, a, b);
  endtask
  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("err_c0", 16'(err_c0), 16'(e.e0));
      chk("err_c1", 16'(err_c1), 16'(e.e1));
      chk("err_conflict", 16'(err_conflict), 16'(e.cf));
      chk("err_any", 16'(err_any), 16'(e.any));
      chk("cycles_c0", cycles_c0, e.c0);
      chk("cycles_c1", cycles_c1, e.c1);
    end
  end
  task automatic gen(input int c, output logic [2:0] v);
    if (grem[c] <= 0) begin
      int r, n;
      r = int'($urandom_range(0, 99));
      if (r < 78) n = gcol[c] == 4 ? 1 : gcol[c] == 1 ? 2 : 4;
      else if (r < 86) n = 0;
      else if (r < 93) n = int'($urandom_range(0, 7));
      else n = ($urandom_range(0, 2) == 0) ? 4 : ($urandom_range(0, 1) == 0) ? 1 : 2;
      gcol[c] = n;
      grem[c] = ring(n) >= 0 ? tim(n) + int'($urandom_range(0, 4)) - 2 : int'($urandom_range(1, 3));
      if (grem[c] < 1) grem[c] = 1;
    end
    grem[c]--;
    v = 3'(gcol[c]);
  endtask
  initial begin
    int rst_rem, off_rem;
    logic [2:0] a, b;
    bit rn, en;
    model_reset();
    gcol[0] = 4; gcol[1] = 2; grem[0] = 0; grem[1] = 0; rst_rem = 0; off_rem = 0;
    repeat (3) cyc_step(0, 1, 0, D, D);
    // three legal cycles on channel 0
    repeat (3) begin run(R, D, RED); run(G, D, GRN); run(Y, D, YEL); end
    run(R, D, RED);
    // green overstay
    run(G, D, 7); run(Y, D, YEL); run(R, D, RED);
    // channel 1: RED->YELLOW, illegal code, clear alongside another RED->YELLOW
    run(D, R, RED); run(D, Y, YEL); run(D, 3'b110, 2); run(D, Y, 1); run(D, R, RED);
    run(D, Y, 1, 1, 1); run(D, Y, 1); run(D, R, 3);
    // conflict overlap then clear
    run(G, G, 1); run(Y, R, 3); run(Y, R, 1, 1, 1); run(R, R, 3);
    // reset mid-green, release on yellow
    run(G, D, 2); repeat (2) cyc_step(0, 1, 0, G, D);
    run(Y, D, YEL); run(R, D, RED); run(G, D, GRN);
    // monitor disabled across illegal codes
    run(3'b111, 3'b011, 20, 0); run(R, R, 9); run(G, D, GRN); run(Y, D, YEL); run(R, D, 3, 1, 1);
    for (int i = 0; i < 4000; i++) begin
      if (rst_rem == 0 && $urandom_range(0, 499) == 0) rst_rem = int'($urandom_range(1, 3));
      rn = rst_rem == 0;
      if (rst_rem > 0) rst_rem--;
      if (off_rem == 0 && $urandom_range(0, 149) == 0) off_rem = int'($urandom_range(3, 25));
      en = off_rem == 0;
      if (off_rem > 0) off_rem--;
      gen(0, a); gen(1, b);
      cyc_step(rn, en, $urandom_range(0, 29) == 0, a, b);
    end
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
